// File: rtl/opendrain_output.sv
// Open-drain iCE40 pin driver: pulls low or releases to the pad pullup, then reports settled
// bus status (held low by another device, stuck high while driven); OPENDRAIN_OUTPUT_HOLD_TIMEOUT_EN adds a held-low timeout.
module opendrain_output #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned FAULT_FILTER  = 3,
  parameter int unsigned HOLD_TIMEOUT  = 1000
) (
  input  logic clk,
  input  logic rst,
  inout  wire  pin,
  input  logic drive_low,
  output logic line_value,
  output logic settled,
  output logic held_low,
  output logic fault,
  input  logic clear_fault,
  output logic hold_timeout
);

  localparam logic [7:0] SETTLE_INIT = 8'(SETTLE_CYCLES);
  localparam logic [7:0] FAULT_LIM   = 8'(FAULT_FILTER);

  typedef enum logic [1:0] {
    REL_SETTLE,
    RELEASED,
    DRV_SETTLE,
    DRIVING
  } state_t;

  state_t     state_q, state_d;
  logic       oe_q;
  logic       pad_in;
  logic       sync_q;
  logic [7:0] settle_q, settle_d;
  logic [7:0] mis_q, mis_d;
  logic       settled_d, held_d, fault_d;
  logic       drv_side, oe_change;

`ifdef SYNTHESIS
  SB_IO #(
    .PIN_TYPE (6'b1010_01),
    .PULLUP   (1'b1)
  ) u_pad (
    .PACKAGE_PIN   (pin),
    .OUTPUT_ENABLE (oe_q),
    .D_OUT_0       (1'b0),
    .D_IN_0        (pad_in)
  );
`else
  assign pin    = oe_q ? 1'b0 : 1'bz;
  assign pad_in = pin;
`endif

  // oe_q resets asynchronously so the pin is released even mid-drive
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oe_q       <= 1'b0;
      sync_q     <= 1'b1;
      line_value <= 1'b1;
    end else begin
      oe_q       <= drive_low;
      sync_q     <= pad_in;
      line_value <= sync_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= REL_SETTLE;
      settle_q <= SETTLE_INIT;
      mis_q    <= 8'd0;
      settled  <= 1'b0;
      held_low <= 1'b0;
      fault    <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      mis_q    <= mis_d;
      settled  <= settled_d;
      held_low <= held_d;
      fault    <= fault_d;
    end
  end

  // The state remembers which side it tracks; disagreement with oe_q is an enable change.
  assign drv_side  = (state_q == DRV_SETTLE) || (state_q == DRIVING);
  assign oe_change = (oe_q != drv_side);

  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    mis_d     = 8'd0;
    settled_d = settled;
    held_d    = 1'b0;
    fault_d   = fault & ~clear_fault;
    if (oe_change) begin
      state_d   = oe_q ? DRV_SETTLE : REL_SETTLE;
      settle_d  = SETTLE_INIT;
      settled_d = 1'b0;
    end else begin
      case (state_q)
        REL_SETTLE, DRV_SETTLE: begin
          settle_d = (settle_q == 8'd0) ? 8'd0 : settle_q - 8'd1;
          if (settle_d == 8'd0) begin
            state_d   = (state_q == DRV_SETTLE) ? DRIVING : RELEASED;
            settled_d = 1'b1;
          end
        end
        RELEASED: held_d = ~line_value;
        DRIVING: begin
          if (line_value) begin
            mis_d = (mis_q >= FAULT_LIM) ? FAULT_LIM : mis_q + 8'd1;
            if ((mis_d == FAULT_LIM) && (mis_q != FAULT_LIM)) fault_d = 1'b1;
          end
        end
        default: state_d = REL_SETTLE;
      endcase
    end
    if (clear_fault) mis_d = 8'd0;
  end

`ifdef OPENDRAIN_OUTPUT_HOLD_TIMEOUT_EN
  localparam logic [19:0] HOLD_LIM = 20'(HOLD_TIMEOUT);
  logic [19:0] hold_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q       <= 20'd0;
      hold_timeout <= 1'b0;
    end else begin
      if (!held_low)              hold_q <= 20'd0;
      else if (hold_q != HOLD_LIM) hold_q <= hold_q + 20'd1;
      if (held_low && (hold_q == HOLD_LIM - 20'd1)) hold_timeout <= 1'b1;
      else if (clear_fault)                         hold_timeout <= 1'b0;
    end
  end
`else
  logic unused_hold_cfg;
  assign unused_hold_cfg = (HOLD_TIMEOUT != 0);
  assign hold_timeout    = 1'b0;
`endif

endmodule
